// File: rtl/reg_operand_fetch.sv
// Operand-fetch front end on the read side of the MIPS register file: S1 (read in flight) -> OUT (registered, back-pressurable).
// Define OPFETCH_BYPASS_EN to build the same-cycle writeback bypass; without it operands come from the register file only.
module reg_operand_fetch #(
    parameter int TAG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [4:0]       i_rs,
    input  logic [4:0]       i_rt,
    input  logic [TAG_W-1:0] i_tag,
    output logic [4:0]       o_raddr1,
    output logic [4:0]       o_raddr2,
    input  logic [31:0]      i_rdata1,
    input  logic [31:0]      i_rdata2,
    input  logic             i_wb_we,
    input  logic [4:0]       i_wb_waddr,
    input  logic [31:0]      i_wb_wdata,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [31:0]      o_op1,
    output logic [31:0]      o_op2,
    output logic [TAG_W-1:0] o_tag
);

    localparam int DATA_W = 32;

    logic              vld_p1;
    logic              first_p1;
    logic [4:0]        rs_p1;
    logic [4:0]        rt_p1;
    logic [TAG_W-1:0]  tag_p1;
    logic [DATA_W-1:0] hold1_p1;
    logic [DATA_W-1:0] hold2_p1;
    logic              byp1_p1;
    logic              byp2_p1;
    logic [DATA_W-1:0] wbdata_p1;

    logic              accept;
    logic              s1_advance;
    logic [DATA_W-1:0] sel1;
    logic [DATA_W-1:0] sel2;

    function automatic logic [DATA_W-1:0] select_operand(
        input logic [4:0]        addr,
        input logic              byp,
        input logic [DATA_W-1:0] bdata,
        input logic              first,
        input logic [DATA_W-1:0] rdata,
        input logic [DATA_W-1:0] hold
    );
        if (addr == 5'd0)
            return '0;
        else if (byp)
            return bdata;
        else if (first)
            return rdata;
        else
            return hold;
    endfunction

    assign o_raddr1    = i_rs;
    assign o_raddr2    = i_rt;
    assign s1_advance  = vld_p1 && (!o_out_valid || i_out_ready);
    assign o_req_ready = i_rst_n && (!vld_p1 || s1_advance);
    assign accept      = i_req_valid && o_req_ready;

    assign sel1 = select_operand(rs_p1, byp1_p1, wbdata_p1, first_p1, i_rdata1, hold1_p1);
    assign sel2 = select_operand(rt_p1, byp2_p1, wbdata_p1, first_p1, i_rdata2, hold2_p1);

`ifdef OPFETCH_BYPASS_EN
    // The register file returns the pre-write value on a same-cycle write/read, so capture the write here.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            byp1_p1   <= i_wb_we && (i_wb_waddr == i_rs);
            byp2_p1   <= i_wb_we && (i_wb_waddr == i_rt);
            wbdata_p1 <= i_wb_wdata;
        end
    end
`else
    logic unused_wb;
    assign unused_wb = ^{i_wb_we, i_wb_waddr, i_wb_wdata};
    assign byp1_p1   = 1'b0;
    assign byp2_p1   = 1'b0;
    assign wbdata_p1 = '0;
`endif

    // ---- S1: read in flight ----
    always_ff @(posedge i_clk) begin
        if (accept) begin
            rs_p1  <= i_rs;
            rt_p1  <= i_rt;
            tag_p1 <= i_tag;
        end
        // i_rdata is only good for one cycle; freeze the snapshot for a stalled S1
        if (vld_p1 && first_p1) begin
            hold1_p1 <= sel1;
            hold2_p1 <= sel2;
        end
    end

    // ---- OUT: registered output ----
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            vld_p1      <= 1'b0;
            first_p1    <= 1'b0;
            o_out_valid <= 1'b0;
            o_op1       <= '0;
            o_op2       <= '0;
            o_tag       <= '0;
        end else begin
            if (accept)
                vld_p1 <= 1'b1;
            else if (s1_advance)
                vld_p1 <= 1'b0;
            first_p1 <= accept;
            if (s1_advance) begin
                o_out_valid <= 1'b1;
                o_op1       <= sel1;
                o_op2       <= sel2;
                o_tag       <= tag_p1;
            end else if (i_out_ready) begin
                o_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_operand_fetch.sv
// Scoreboard bench for reg_operand_fetch: register-file model, snapshot reference model, decoupled output monitor.
module tb_reg_operand_fetch;

    localparam int TAG_W = 4;
`ifdef OPFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [4:0]       rs = '0;
    logic [4:0]       rt = '0;
    logic [TAG_W-1:0] tag = '0;
    logic [4:0]       raddr1;
    logic [4:0]       raddr2;
    logic [31:0]      rdata1 = '0;
    logic [31:0]      rdata2 = '0;
    logic             wb_we = 1'b0;
    logic [4:0]       wb_waddr = '0;
    logic [31:0]      wb_wdata = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      op1;
    logic [31:0]      op2;
    logic [TAG_W-1:0] otag;

    typedef struct {
        logic [31:0]      op1;
        logic [31:0]      op2;
        logic [TAG_W-1:0] tag;
        int               acc;
    } item_t;

    item_t       q[$];
    logic [31:0] rf[32];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    reg_operand_fetch #(.TAG_W(TAG_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_rs(rs), .i_rt(rt), .i_tag(tag),
        .o_raddr1(raddr1), .o_raddr2(raddr2),
        .i_rdata1(rdata1), .i_rdata2(rdata2),
        .i_wb_we(wb_we), .i_wb_waddr(wb_waddr), .i_wb_wdata(wb_wdata),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_op1(op1), .o_op2(op2), .o_tag(otag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read register file: a same-edge write is not visible to the read.
    always @(posedge clk) begin
        rdata1 <= rf[raddr1];
        rdata2 <= rf[raddr2];
        if (wb_we) rf[wb_waddr] <= wb_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Operand value = register contents after this cycle's write (bypass build) or before it.
    function automatic logic [31:0] model_op(input logic [4:0] r, input logic we, input logic [4:0] wa,
                                             input logic [31:0] wd);
        if (r == 5'd0) return 32'd0;
        if (BYP && we && wa == r) return wd;
        return rf[r];
    endfunction

    task automatic step(input bit v, input logic [4:0] a1, input logic [4:0] a2, input logic [TAG_W-1:0] t,
                        input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        input bit ordy, input bit rn, output bit acc);
        item_t it;
        bit    exp_rdy;
        @(negedge clk);
        req_valid = v; rs = a1; rt = a2; tag = t;
        wb_we = we; wb_waddr = wa; wb_wdata = wd;
        out_ready = ordy; rst_n = rn;
        if (!rn) q.delete();
        #1;
        exp_rdy = rn && (q.size() < 2 || ordy);
        check("req_ready", {31'd0, req_ready}, {31'd0, exp_rdy});
        acc = v && req_ready;
        if (acc) begin
            it.op1 = model_op(a1, we, wa, wd);
            it.op2 = model_op(a2, we, wa, wd);
            it.tag = t;
            it.acc = cyc;
            q.push_back(it);
        end
    endtask

    task automatic idle_write(input logic [4:0] wa, input logic [31:0] wd);
        bit a;
        step(1'b0, 5'd0, 5'd0, '0, 1'b1, wa, wd, 1'b1, 1'b1, a);
    endtask

    // Monitor: compares whatever OUT presents against the head of the scoreboard.
    initial begin
        bit presented = 1'b0;
        int last_cons = 0;
        int exp_c;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                presented = 1'b0;
                last_cons = 0;
            end else if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out", 32'(otag), 32'hFFFF_FFFF);
                end else begin
                    check("op1", op1, q[0].op1);
                    check("op2", op2, q[0].op2);
                    check("tag", 32'(otag), 32'(q[0].tag));
                    if (!presented) begin
                        exp_c = (q[0].acc + 2 > last_cons + 1) ? q[0].acc + 2 : last_cons + 1;
                        check("latency", 32'(cyc), 32'(exp_c));
                        presented = 1'b1;
                    end
                    if (out_ready) begin
                        void'(q.pop_front());
                        last_cons = cyc;
                        presented = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        bit acc;
        logic [4:0] a1, a2, wa;

        // Load every register through the write port while in reset.
        for (int i = 0; i < 32; i++)
            step(1'b0, 5'd0, 5'd0, '0, 1'b1, 5'(i), $urandom, 1'b0, 1'b0, acc);

        // Basic read
        idle_write(5'd5, 32'h1234_5678);
        idle_write(5'd7, 32'hDEAD_BEEF);
        step(1'b1, 5'd5, 5'd7, 4'd3, 1'b0, 5'd0, '0, 1'b1, 1'b1, acc);
        repeat (3) step(1'b0, 5'd0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 1'b1, acc);

        // Zero register with a garbage entry 0, and rs == rt
        idle_write(5'd0, 32'hFFFF_FFFF);
        step(1'b1, 5'd0, 5'd0, 4'd4, 1'b1, 5'd0, 32'h1111_1111, 1'b1, 1'b1, acc);
        step(1'b1, 5'd7, 5'd7, 4'd5, 1'b0, 5'd0, '0, 1'b1, 1'b1, acc);

        // Same-cycle writeback bypass
        idle_write(5'd9, 32'h0000_0001);
        step(1'b1, 5'd9, 5'd5, 4'd6, 1'b1, 5'd9, 32'hA5A5_A5A5, 1'b1, 1'b1, acc);
        repeat (3) step(1'b0, 5'd0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 1'b1, acc);

        // Backpressure: two accepts fill the block, later writes must not leak in
        step(1'b1, 5'd10, 5'd11, 4'd1, 1'b0, 5'd0, '0, 1'b0, 1'b1, acc);
        step(1'b1, 5'd12, 5'd13, 4'd2, 1'b0, 5'd0, '0, 1'b0, 1'b1, acc);
        for (int i = 0; i < 4; i++)
            step(1'b1, 5'd14, 5'd15, 4'd3, 1'b1, 5'(10 + i), $urandom, 1'b0, 1'b1, acc);
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++)
            step(1'b1, 5'd14, 5'd15, 4'd3, 1'b0, 5'd0, '0, 1'b1, 1'b1, acc);
        check("bp_tag3_accepted", {31'd0, acc}, 32'd1);

        // Streaming
        for (int i = 0; i < 16; i++)
            step(1'b1, 5'($urandom), 5'($urandom), 4'(i), $urandom_range(0, 1) == 1, 5'($urandom), $urandom,
                 1'b1, 1'b1, acc);

        // Random traffic with a two-cycle reset in the middle
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                step(1'b1, 5'd1, 5'd2, '0, 1'b0, 5'd0, '0, 1'b0, 1'b0, acc);
                step(1'b1, 5'd1, 5'd2, '0, 1'b0, 5'd0, '0, 1'b1, 1'b0, acc);
                check("rst_out_valid", {31'd0, out_valid}, 32'd0);
                check("rst_op1", op1, 32'd0);
                check("rst_op2", op2, 32'd0);
                check("rst_tag", 32'(otag), 32'd0);
            end
            a1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom);
            wa = ($urandom_range(0, 2) == 0) ? a1 : (($urandom_range(0, 2) == 0) ? a2 : 5'($urandom));
            step($urandom_range(0, 3) != 0, a1, a2, 4'($urandom), $urandom_range(0, 1) == 1, wa, $urandom,
                 $urandom_range(0, 3) != 0, 1'b1, acc);
        end

        for (int i = 0; i < 20 && q.size() != 0; i++)
            step(1'b0, 5'd0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 1'b1, acc);
        #5;
        check("drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
